// File: rtl/pwm_generator.sv
// Three-channel PWM driven by a shared tick/step period counter, plus the
// end-of-period load strobes that tell the controller when to update duties.
module pwm_generator #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int PWM_FREQ   = 50,
  parameter int STEPS      = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] rear_motor,
  input  logic [6:0] front_motor,
  input  logic [6:0] servo,
  output logic       rear_pwm,
  output logic       front_pwm,
  output logic       servo_pwm,
  output logic       load_rear,
  output logic       load_front,
  output logic       load_servo_out
);

  localparam int TICKS = CLOCK_FREQ / (PWM_FREQ * STEPS);
  localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int CW    = ((SW > 7) ? SW : 7) + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);
  localparam logic [CW-1:0] STEPS_C   = CW'(STEPS);

  logic [TW-1:0] tick_reg, tick_next;
  logic [SW-1:0] step_reg, step_next;
  logic          tick_wrap;
  logic          load_reg, load_next;
  logic [2:0]    pwm_reg, pwm_next;
  logic [6:0]    duty [3];

  assign duty[0] = rear_motor;
  assign duty[1] = front_motor;
  assign duty[2] = servo;

  always_comb begin
    tick_wrap = (tick_reg == TICK_LAST);
    tick_next = tick_wrap ? '0 : tick_reg + TW'(1);
    step_next = step_reg;
    if (tick_wrap) begin
      step_next = (step_reg == STEP_LAST) ? '0 : step_reg + SW'(1);
    end
    // Strobe is registered, so decode the counter values of the coming cycle.
    load_next = (tick_next == TICK_LAST) && (step_next == STEP_LAST);
  end

  // Duty is compared every cycle so a forced zero takes effect immediately.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [CW-1:0] duty_ext;
      logic [CW-1:0] duty_sat;
      assign duty_ext     = CW'(duty[gi]);
      assign duty_sat     = (duty_ext > STEPS_C) ? STEPS_C : duty_ext;
      assign pwm_next[gi] = (CW'(step_reg) < duty_sat);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_reg <= '0;
      step_reg <= '0;
      load_reg <= 1'b0;
      pwm_reg  <= '0;
    end else begin
      tick_reg <= tick_next;
      step_reg <= step_next;
      load_reg <= load_next;
      pwm_reg  <= pwm_next;
    end
  end

  assign rear_pwm       = pwm_reg[0];
  assign front_pwm      = pwm_reg[1];
  assign servo_pwm      = pwm_reg[2];
  assign load_rear      = load_reg;
  assign load_front     = load_reg;
  assign load_servo_out = load_reg;

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: a period-phase reference model queues
// per-cycle expectations, a monitor pops and compares them on the falling edge.
module tb_pwm_generator;
  localparam int STEPS  = 10;
  localparam int TICKS  = 100;
  localparam int PERIOD = STEPS * TICKS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] rear_motor = 7'd5, front_motor = 7'd5, servo = 7'd5;
  logic       rear_pwm, front_pwm, servo_pwm;
  logic       load_rear, load_front, load_servo_out;

  always #5 clk = ~clk;

  pwm_generator #(.CLOCK_FREQ(1000), .PWM_FREQ(1), .STEPS(STEPS)) dut (
    .clk(clk), .rst(rst),
    .rear_motor(rear_motor), .front_motor(front_motor), .servo(servo),
    .rear_pwm(rear_pwm), .front_pwm(front_pwm), .servo_pwm(servo_pwm),
    .load_rear(load_rear), .load_front(load_front), .load_servo_out(load_servo_out)
  );

  typedef struct {
    logic [2:0] pwm;
    logic       load;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_no = 0;

  // Stimulus intent for the upcoming cycles
  bit g_rst = 1'b1;
  int g_duty [3] = '{5, 5, 5};
  bit g_ctrl = 1'b0;
  int g_pending = 0;
  bit load_seen = 1'b0;

  // Reference model: inputs of the previous cycle and phase within the period
  bit m_prev_rst = 1'b1;
  int m_prev_duty [3] = '{5, 5, 5};
  int m_phase = 0;

  function automatic int sat(input int d);
    return (d > STEPS) ? STEPS : d;
  endfunction

  task automatic check(input string name, input logic act, input logic req, input int c);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b required %b", name, c, act, req);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int   new_phase;
      @(posedge clk);
      #1;
      cyc_no++;
      new_phase = m_prev_rst ? 0 : (m_phase + 1) % PERIOD;
      for (int ch = 0; ch < 3; ch++) begin
        e.pwm[ch] = !m_prev_rst && ((m_phase / TICKS) < sat(m_prev_duty[ch]));
      end
      e.load = !m_prev_rst && (new_phase == PERIOD - 1);
      e.cyc  = cyc_no;
      sbq.push_back(e);
      m_phase = new_phase;
      // Controller register model: takes the pending duty on a strobe
      if (g_ctrl && load_seen) g_duty[0] = g_pending;
      rst         = g_rst;
      rear_motor  = 7'(g_duty[0]);
      front_motor = 7'(g_duty[1]);
      servo       = 7'(g_duty[2]);
      m_prev_rst  = g_rst;
      for (int ch = 0; ch < 3; ch++) m_prev_duty[ch] = g_duty[ch];
    end
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(negedge clk);
      load_seen = load_rear;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("rear_pwm",       rear_pwm,       e.pwm[0], e.cyc);
        check("front_pwm",      front_pwm,      e.pwm[1], e.cyc);
        check("servo_pwm",      servo_pwm,      e.pwm[2], e.cyc);
        check("load_rear",      load_rear,      e.load,   e.cyc);
        check("load_front",     load_front,     e.load,   e.cyc);
        check("load_servo_out", load_servo_out, e.load,   e.cyc);
        if (e.load) $display("strobe expected at cycle %0d, seen %b", e.cyc, load_rear);
      end
    end
  end

  initial begin : driver
    // Reset hold with 5/5/5, then one full period
    g_rst = 1'b1; g_duty = '{5, 5, 5};
    cyc(3);
    g_rst = 1'b0;
    cyc(PERIOD + 5);

    // Extremes: 0, full scale, saturated
    g_rst = 1'b1; g_duty = '{0, 10, 127};
    cyc(2);
    g_rst = 1'b0;
    cyc(3 * PERIOD + 10);

    // Period-boundary update: controller holds 7, loads 3 on the strobe
    g_rst = 1'b1; g_duty = '{7, 7, 7};
    cyc(1);
    g_rst = 1'b0; g_ctrl = 1'b1; g_pending = 3;
    cyc(2 * PERIOD + 100);
    g_ctrl = 1'b0;

    // Mid-period clear at P0+200
    g_rst = 1'b1; g_duty = '{9, 9, 9};
    cyc(1);
    g_rst = 1'b0;
    cyc(200);
    g_duty = '{0, 0, 0};
    cyc(900);

    // Reset at P0+650, then a fresh period
    g_rst = 1'b1; g_duty = '{5, 5, 5};
    cyc(1);
    g_rst = 1'b0;
    cyc(650);
    g_rst = 1'b1;
    cyc(1);
    g_rst = 1'b0;
    cyc(PERIOD + 100);

    // Randomized segments with occasional reset
    for (int s = 0; s < 25; s++) begin
      g_rst = ($urandom_range(0, 9) == 0);
      for (int ch = 0; ch < 3; ch++) g_duty[ch] = $urandom_range(0, 127);
      cyc($urandom_range(1, 400));
    end
    g_rst = 1'b0;
    cyc(PERIOD + 10);

    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Three-channel PWM stage directly downstream of the motor controller. It takes the rear-motor, front-motor and servo duty values and produces the three PWM drive outputs. It also issues the `load_rear`, `load_front` and `load_servo_out` strobes that tell the controller when to copy newly received duty values into its output registers. All three channels share one period counter, so duty updates take effect only on period boundaries.

## Interface
Parameters:
- `CLOCK_FREQ`, 50000000: clock frequency in Hz.
- `PWM_FREQ`, 50: PWM period rate in Hz; 50 Hz gives a 20 ms period, suitable for the servo.
- `STEPS`, 100: duty resolution in steps per period; duty value N means N/STEPS high time.
- `TICKS` (localparam), CLOCK_FREQ / (PWM_FREQ*STEPS): clocks per step; must be ≥1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rear_motor`  in  7  rear motor duty, unsigned.
- `front_motor`  in  7  front motor duty, unsigned.
- `servo`  in  7  servo duty, unsigned.
- `rear_pwm`  out  1  rear motor PWM.
- `front_pwm`  out  1  front motor PWM.
- `servo_pwm`  out  1  servo PWM.
- `load_rear`  out  1  one-cycle strobe in the last cycle of each period.
- `load_front`  out  1  one-cycle strobe in the last cycle of each period.
- `load_servo_out`  out  1  one-cycle strobe in the last cycle of each period.

## Operation
- Tick counter `tick`, width $clog2(TICKS) (minimum 1 bit), counts 0..TICKS-1 and then wraps to 0.
- Step counter `step`, width $clog2(STEPS), increments only when tick==TICKS-1, and wraps from STEPS-1 to 0.
- Period = STEPS*TICKS clocks. Period start is the cycle with tick==0 and step==0.
- Per channel, saturated duty d' = min(duty, STEPS).
  - The comparison is zero-extended and unsigned.
  - duty ≥ STEPS means constantly high; duty 0 means constantly low.
- Each PWM output is registered: `x_pwm <= (step < d')`. Duty is sampled every cycle, not latched per period.
  - Consequence: a mid-period change from the controller (e.g. its timeout clear forcing 0) takes effect one cycle later, without waiting for the boundary. This is required for safe shutdown.
- Load strobes:
  - All three are the same registered signal.
  - They are high exactly in the cycle where tick==TICKS-1 and step==STEPS-1, and low otherwise.
  - Strobes are generated continuously and unconditionally. The controller decides what is loaded.
- There is no other state machine. Behaviour is fully determined by the two counters.

## Timing
- Reset:
  - While rst is high at a clock edge: tick=0, step=0, all `*_pwm`=0, all `load_*`=0.
  - The first cycle after rst deasserts is period start, P0.
  - Reset asserted mid-period abandons the period; there is no strobe for that partial period.
- PWM latency:
  - Outputs lag the counters by one cycle.
  - For period start at cycle P and constant duty N (0<N<STEPS), `x_pwm` is high on cycles P+1 .. P+N*TICKS inclusive and low on all other cycles of the period.
  - For N ≥ STEPS, `x_pwm` is high continuously from P0+1 onward.
- Load handshake:
  - The strobe is high in cycle P+STEPS*TICKS-1.
  - The controller register updates at the end of that cycle, so the new duty is visible at the next period start P'.
  - The PWM output reflects the new duty from P'+1. The first full period with the new duty is therefore glitch-free.
- Strobe spacing is exactly STEPS*TICKS cycles; there are never two strobes closer than that.
- TICKS=1 is legal: the strobe is high whenever step==STEPS-1.

## Test plan
Bench parameters: CLOCK_FREQ=1000, PWM_FREQ=1, STEPS=10, so TICKS=100 and the period is 1000 cycles.
- **Reset values.** Hold rst for 3 cycles with duties 5/5/5 → during reset all outputs are 0. After release, `x_pwm` rises at P0+1, stays high for 500 cycles and falls at P0+501.
- **Duty extremes.**
  - rear=0 → `rear_pwm` stays 0 for 3 periods.
  - front=10 → `front_pwm` is constantly 1 from P0+1.
  - servo=127 → `servo_pwm` is constantly 1 (saturation).
- **Load strobes.** Run 3 periods → `load_rear`/`load_front`/`load_servo_out` are each high exactly once per period, at cycles P0+999, +1999 and +2999, each for a single cycle, all coincident.
- **Period-boundary update.** Model the controller register as loading 3 on the strobe while presenting 7 → the next period's pulse is exactly 300 cycles wide, with no partial pulse.
- **Mid-period clear.** With duty 9, force duty to 0 at P0+200 → `x_pwm` goes low at P0+201 and stays low.
- **Reset mid-operation.** Assert rst at P0+650 for 1 cycle with duty 5 → outputs go low and no strobe occurs at P0+999. A new period restarts after release: pulse width 500 cycles, strobe 999 cycles after the restart.
